// File: rtl/core_cluster.sv
// Cluster of SIMD core units sharing one broadcast instruction stream, plus a
// global register file, a core enable mask and a serial result port.

module core_unit #(
   parameter int BIT_WIDTH  = 8,
   parameter int NR_GLOBALS = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            i_execute,
   input  logic [15:0]                     i_opcode,
   input  logic [NR_GLOBALS*BIT_WIDTH-1:0] i_globals,
   output logic [2*BIT_WIDTH-1:0]          o_accu
);
   localparam int AW = 2 * BIT_WIDTH;

   logic [AW-1:0]        r_accu;
   logic [AW-1:0]        w_imm;
   logic [AW-1:0]        w_gext;
   logic [AW-1:0]        w_prod;
   logic [BIT_WIDTH-1:0] w_gval;

   // Unimplemented global indices read as zero.
   always_comb begin
      w_gval = '0;
      for (int g = 0; g < NR_GLOBALS; g++) begin
         if (i_opcode[11:8] == 4'(g)) begin
            w_gval = i_globals[g*BIT_WIDTH +: BIT_WIDTH];
         end
      end
   end

   assign w_imm  = AW'(i_opcode[7:0]);
   assign w_gext = AW'(w_gval);
   assign w_prod = AW'(r_accu[BIT_WIDTH-1:0]) * w_gext;

   // Only class 2'b00 opcodes are arithmetic; everything else is a no-op here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_accu <= '0;
      end else if (i_execute && (i_opcode[15:14] == 2'b00)) begin
         case (i_opcode[13:12])
            2'b00:   r_accu <= w_imm;
            2'b01:   r_accu <= r_accu + w_imm;
            2'b10:   r_accu <= r_accu + w_gext;
            default: r_accu <= w_prod;
         endcase
      end
   end

   assign o_accu = r_accu;
endmodule

module core_cluster #(
   parameter int NR_CORES   = 4,
   parameter int BIT_WIDTH  = 8,
   parameter int NR_GLOBALS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] opcode,
   input  logic        execute,
   output logic        ready,
   output logic        valid_bit,
   output logic        output_bit
);
   localparam int AW   = 2 * BIT_WIDTH;
   localparam int SELW = $clog2(NR_CORES);
   localparam int CNTW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t                        r_state;
   state_t                        w_stateNext;
   logic [NR_CORES-1:0]           r_mask;
   logic [NR_CORES-1:0]           w_maskNext;
   logic [NR_CORES-1:0]           w_selOneHot;
   logic [NR_CORES-1:0]           w_coreExec;
   logic [BIT_WIDTH-1:0]          r_globals [NR_GLOBALS];
   logic [NR_GLOBALS*BIT_WIDTH-1:0] w_globalsFlat;
   logic [NR_CORES*AW-1:0]        w_accuFlat;
   logic [AW-1:0]                 w_selAccu;
   logic [BIT_WIDTH-1:0]          w_storeVal;
   logic                          w_anyEnabled;
   logic [SELW-1:0]               w_sel;
   logic [3:0]                    w_gidx;
   logic                          w_accept;
   logic                          w_misc;
   logic [BIT_WIDTH-1:0]          r_shift;
   logic [CNTW-1:0]               r_cnt;
   logic                          r_valid;
   logic                          r_outBit;

   assign ready    = (r_state == S_IDLE);
   assign w_accept = execute & ready;
   assign w_misc   = (opcode[15:14] == 2'b11);
   assign w_sel    = opcode[SELW+8:9];
   assign w_gidx   = opcode[12:9];

   genvar y;
   generate
      for (y = 0; y < NR_CORES; y++) begin : g_core
         assign w_coreExec[y]  = w_accept & r_mask[y];
         assign w_selOneHot[y] = (w_sel == SELW'(y));
         core_unit #(.BIT_WIDTH(BIT_WIDTH), .NR_GLOBALS(NR_GLOBALS)) u_core (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_execute (w_coreExec[y]),
            .i_opcode  (opcode),
            .i_globals (w_globalsFlat),
            .o_accu    (w_accuFlat[y*AW +: AW])
         );
      end
      for (y = 0; y < NR_GLOBALS; y++) begin : g_glob
         assign w_globalsFlat[y*BIT_WIDTH +: BIT_WIDTH] = r_globals[y];
      end
   endgenerate

   // Descending scan so the lowest-indexed enabled core wins.
   always_comb begin
      w_selAccu    = '0;
      w_storeVal   = '0;
      w_anyEnabled = 1'b0;
      for (int c = NR_CORES - 1; c >= 0; c--) begin
         if (w_selOneHot[c]) begin
            w_selAccu = w_accuFlat[c*AW +: AW];
         end
         if (r_mask[c]) begin
            w_anyEnabled = 1'b1;
            w_storeVal   = w_accuFlat[c*AW +: BIT_WIDTH];
         end
      end
   end

   always_comb begin
      case (opcode[6:5])
         2'b00:   w_maskNext = r_mask;
         2'b01:   w_maskNext = w_selOneHot;
         2'b10:   w_maskNext = '1;
         default: w_maskNext = r_mask ^ w_selOneHot;
      endcase
   end

   // Store reads the pre-instruction mask, so an enable change in the same
   // opcode does not affect which core supplies the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask <= '1;
         for (int g = 0; g < NR_GLOBALS; g++) begin
            r_globals[g] <= '0;
         end
      end else if (w_accept && w_misc) begin
         r_mask <= w_maskNext;
         if (opcode[7] && w_anyEnabled) begin
            for (int g = 0; g < NR_GLOBALS; g++) begin
               if (w_gidx == 4'(g)) begin
                  r_globals[g] <= w_storeVal;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept && w_misc && opcode[3]) begin
               w_stateNext = S_STREAM;
            end
         end
         S_STREAM: begin
            if (r_cnt == CNTW'(BIT_WIDTH - 1)) begin
               w_stateNext = S_IDLE;
            end
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

   // Bit 0 is presented straight from the capture edge; the shifter holds the rest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift  <= '0;
         r_cnt    <= '0;
         r_valid  <= 1'b0;
         r_outBit <= 1'b0;
      end else if (r_state == S_STREAM) begin
         if (r_cnt == CNTW'(BIT_WIDTH - 1)) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
         end else begin
            r_outBit <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_cnt    <= r_cnt + 1'b1;
         end
      end else begin
         r_valid <= 1'b0;
         if (w_accept && w_misc) begin
            if (opcode[3]) begin
               r_valid  <= 1'b1;
               r_outBit <= w_selAccu[0];
               r_shift  <= w_selAccu[BIT_WIDTH-1:0] >> 1;
               r_cnt    <= '0;
            end else if (opcode[4]) begin
               r_valid  <= 1'b1;
               r_outBit <= w_selAccu[0];
            end
         end
      end
   end

   assign valid_bit  = r_valid;
   assign output_bit = r_outBit;
endmodule

// File: doc/core_cluster.md
CORE_CLUSTER -- requirements
Module: core_cluster

Interface
REQ-001 SHALL have parameter NR_CORES, default 4, number of instantiated core units (2..8).
REQ-002 SHALL have parameter BIT_WIDTH, default 8, core data width; each core accumulator is 2*BIT_WIDTH bits.
REQ-003 SHALL have parameter NR_GLOBALS, default 16, number of global registers (1..16), each BIT_WIDTH bits.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port opcode, input, 16, instruction broadcast to all cores.
REQ-007 SHALL have port execute, input, 1, the instruction is valid this cycle.
REQ-008 SHALL have port ready, output, 1, high when an instruction can be accepted.
REQ-009 SHALL have port valid_bit, output, 1, output_bit carries data this cycle.
REQ-010 SHALL have port output_bit, output, 1, serial result bit.

Function
REQ-011 SHALL accept an instruction only when execute=1 and ready=1; execute while ready=0 SHALL be ignored completely, including by the cores.
REQ-012 SHALL drive core y execute as execute AND ready AND enable_mask[y]; every core sees opcode unchanged and a flattened view of all global registers.
REQ-013 SHALL take the core index from opcode[CLOG2(NR_CORES)+8:9] and the global index from opcode[12:9].
REQ-014 SHALL decode misc commands only when opcode[15:14]=2'b11; other opcodes SHALL affect only the cores.
REQ-015 Global store (opcode[7]=1) SHALL write accu[BIT_WIDTH-1:0] of the lowest-indexed enabled core into global[opcode[12:9]]; with no core enabled, or index >= NR_GLOBALS, SHALL perform no write.
REQ-016 Enable control opcode[6:5]: 00 no change; 01 mask = only the selected core; 10 mask = all ones; 11 toggle the selected core's mask bit.
REQ-017 A global store and an enable change in one instruction SHALL use the mask as it was before that instruction.
REQ-018 Single-bit output (opcode[4]=1, opcode[3]=0) SHALL set output_bit to accu[sel][0] and pulse valid_bit for exactly one cycle, on the edge after acceptance.
REQ-019 Stream output (opcode[3]=1, opcode[4] ignored) SHALL capture accu[sel][BIT_WIDTH-1:0] at the acceptance edge.
REQ-020 While streaming, the block SHALL shift the captured value out LSB first, one bit per cycle for BIT_WIDTH cycles, with valid_bit=1 on each.
REQ-021 While streaming, ready SHALL be 0 from the cycle after acceptance through the cycle with the last valid bit; ready SHALL return to 1 in the following cycle.
REQ-022 The streaming state machine SHALL have two states. IDLE moves to STREAM on an accepted stream instruction; STREAM moves to IDLE when its bit counter reaches BIT_WIDTH-1.
REQ-023 valid_bit SHALL be 0 whenever neither a single-bit pulse nor a stream bit is in progress.
REQ-024 output_bit SHALL hold its last value when valid_bit=0.
REQ-025 Cores SHALL update their accumulators at the same edge that accepts an instruction; all captures in REQ-015, REQ-018 and REQ-019 use the accumulator value before that edge.

Reset
REQ-026 While rst_n=0, and immediately on its assertion, the block SHALL set: enable_mask all ones, all globals 0, state IDLE, bit counter 0, ready=1, valid_bit=0, output_bit=0.
REQ-027 Reset asserted mid-stream SHALL abort the stream without emitting further valid bits.
REQ-028 The cores SHALL be reset by the same rst_n.

Verification
REQ-029 Bench SHALL cover single select: after reset, send opcode 16'hC220 (select core 1) then an arithmetic opcode -> only core 1's accumulator changes.
REQ-030 Bench SHALL cover global store: with core 2 holding accu=16'h00A5 and mask=4'b1100, send 16'hC680 (store to global 3) -> global[3]=8'hA5 and core 3's value is not used.
REQ-031 Bench SHALL cover streaming: with core 0 holding accu low byte 8'b1011_0010, send 16'hC008 -> output_bit 0,1,0,0,1,1,0,1 on 8 consecutive cycles with valid_bit=1, and ready low for exactly those 8 cycles.
REQ-032 Bench SHALL cover a busy instruction: while streaming, present execute=1 with 16'hC040 -> mask unchanged, cores not executed, and the stream completes intact.
REQ-033 Bench SHALL cover toggle: send 16'hC060 twice with core 0 selected -> mask bit 0 goes from 1 to 0 and back to 1.
REQ-034 Bench SHALL cover reset mid-stream: drop rst_n at stream bit 3 -> valid_bit=0 and ready=1 at once, and the mask returns to all ones.
